// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH bits with valid/ready at both
// ends, bubble collapsing, and a registered occupancy count.
module dff_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; ready may depend combinationally on the downstream ready, valid never
  // depends on ready, and a valid beat is held stable until it transfers.

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] ld;
  logic             push, pop;

  // ld[i]: stage i takes whatever sits in stage i-1 (or the input) this edge.
  // A stage can load when empty or when it is itself moving on.
  always_comb begin
    logic down_ready;
    ld         = '0;
    down_ready = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ld[i]      = en & ~flush & (~v_q[i] | down_ready);
      down_ready = ld[i];
    end
  end

  assign pop      = en & v_q[DEPTH-1] & out_ready & ~flush;
  assign in_ready = ld[0] & reset;
  assign push     = in_valid & in_ready;

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q;
    if (flush) begin
      v_d     = '0;
      count_d = '0;
    end else begin
      if (ld[0]) begin
        v_d[0] = push;
        if (push) d_d[0] = data;
      end
      // Payload only moves with a valid item, so bubbles never overwrite data.
      for (int i = 1; i < DEPTH; i++) begin
        if (ld[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) d_d[i] = d_q[i-1];
        end
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign q         = out_valid ? d_q[DEPTH-1] : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=4): reset, streaming, backpressure,
// bubble collapse, enable freeze, flush and asynchronous reset.
module tb_dff_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .data(data),
    .in_valid(in_valid), .in_ready(in_ready), .q(q), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1-2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      en = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      data = 8'($urandom_range(0, 255));
      #1;
      n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q k=%0d got=%h exp=00", k, q); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid k=%0d got=%b exp=0", k, out_valid); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count k=%0d got=%0d exp=0", k, count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready k=%0d got=%b exp=0", k, in_ready); end
    end
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_in_ready got=%b exp=0", in_ready); end
    reset = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_release_count got=%0d exp=0", count); end
  endtask

  // Item j (value j+1) is pushed at edge j, sits in the last stage during cycle
  // j+4 and pops at the edge ending it.
  task automatic test_stream();
    int             pushes, pops;
    logic [7:0]     exp_q;
    logic           exp_v;
    en = 1'b1; out_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      in_valid = (c < 16);
      data     = (c < 16) ? 8'(c + 1) : 8'h00;
      #1;
      pushes = (c < 16) ? c : 16;
      pops   = (c < 4) ? 0 : ((c - 4 < 16) ? c - 4 : 16);
      exp_v  = (c >= 4 && c <= 19);
      exp_q  = exp_v ? 8'(c - 3) : 8'h00;
      n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL stream_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_v); end
      n_checks++; if (q !== exp_q) begin n_fail++; $display("FAIL stream_q c=%0d got=%h exp=%h", c, q, exp_q); end
      n_checks++; if (count !== 3'(pushes - pops)) begin n_fail++; $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, count, pushes - pops); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_seq [6];
    logic [2:0] exp_cnt [6];
    exp_seq[0] = 8'hA0; exp_seq[1] = 8'hA1; exp_seq[2] = 8'hA2;
    exp_seq[3] = 8'hA3; exp_seq[4] = 8'hA4; exp_seq[5] = 8'hA5;
    exp_cnt[0] = 3'd4; exp_cnt[1] = 3'd4; exp_cnt[2] = 3'd4;
    exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd2; exp_cnt[5] = 3'd1;
    en = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data = 8'hA0 + 8'(k); in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_in_ready k=%0d got=%b exp=1", k, in_ready); end
      tick();
    end
    data = 8'hA4;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready k=%0d got=%b exp=0", k, in_ready); end
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_full_count k=%0d got=%0d exp=4", k, count); end
      n_checks++; if (q !== 8'hA0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_head k=%0d got=%h/%b exp=a0/1", k, q, out_valid); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (out_valid !== 1'b1 || q !== exp_seq[i]) begin n_fail++; $display("FAIL bp_drain_q i=%0d got=%h/%b exp=%h/1", i, q, out_valid, exp_seq[i]); end
      n_checks++; if (count !== exp_cnt[i]) begin n_fail++; $display("FAIL bp_drain_count i=%0d got=%0d exp=%0d", i, count, exp_cnt[i]); end
      tick();
      if (i == 0) data = 8'hA5;
      else in_valid = 1'b0;
      #1;
    end
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL bp_empty got=%b/%0d exp=0/0", out_valid, count); end
    tick();
  endtask

  task automatic test_bubble();
    en = 1'b1; out_ready = 1'b0;
    data = 8'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    data = 8'h22; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #1;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL bubble_count got=%0d exp=2", count); end
    n_checks++; if (out_valid !== 1'b1 || q !== 8'h11) begin n_fail++; $display("FAIL bubble_head got=%h/%b exp=11/1", q, out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    tick();
    #1;
    n_checks++; if (out_valid !== 1'b1 || q !== 8'h22) begin n_fail++; $display("FAIL bubble_second got=%h/%b exp=22/1", q, out_valid); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL bubble_count_after got=%0d exp=1", count); end
    tick();
    #1;
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL bubble_empty got=%b/%0d exp=0/0", out_valid, count); end
    tick();
  endtask

  task automatic test_enable();
    logic       exp_v   [6];
    logic [7:0] exp_q   [6];
    logic [2:0] exp_cnt [6];
    exp_v[0] = 1'b1; exp_q[0] = 8'h31; exp_cnt[0] = 3'd3;
    exp_v[1] = 1'b1; exp_q[1] = 8'h32; exp_cnt[1] = 3'd3;
    exp_v[2] = 1'b1; exp_q[2] = 8'h33; exp_cnt[2] = 3'd2;
    exp_v[3] = 1'b0; exp_q[3] = 8'h00; exp_cnt[3] = 3'd1;
    exp_v[4] = 1'b1; exp_q[4] = 8'h34; exp_cnt[4] = 3'd1;
    exp_v[5] = 1'b0; exp_q[5] = 8'h00; exp_cnt[5] = 3'd0;
    en = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data = 8'h31 + 8'(k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    en = 1'b0; in_valid = 1'b1; data = 8'h34; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_freeze_in_ready k=%0d got=%b exp=0", k, in_ready); end
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL en_freeze_count k=%0d got=%0d exp=3", k, count); end
      n_checks++; if (out_valid !== 1'b1 || q !== 8'h31) begin n_fail++; $display("FAIL en_freeze_q k=%0d got=%h/%b exp=31/1", k, q, out_valid); end
      tick();
    end
    en = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL en_resume_in_ready got=%b exp=1", in_ready); end
    for (int j = 0; j < 6; j++) begin
      n_checks++; if (out_valid !== exp_v[j] || q !== exp_q[j]) begin n_fail++; $display("FAIL en_resume_q j=%0d got=%h/%b exp=%h/%b", j, q, out_valid, exp_q[j], exp_v[j]); end
      n_checks++; if (count !== exp_cnt[j]) begin n_fail++; $display("FAIL en_resume_count j=%0d got=%0d exp=%0d", j, count, exp_cnt[j]); end
      tick();
      in_valid = 1'b0;
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_and_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data = 8'h41 + 8'(k); in_valid = 1'b1;
      tick();
    end
    data = 8'h55; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=4", count); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || q !== 8'h00) begin n_fail++; $display("FAIL flush_cleared got=%0d/%b/%h exp=0/0/00", count, out_valid, q); end
    tick();
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_nothing_accepted got=%0d exp=0", count); end
    out_ready = 1'b0;
    data = 8'h61; in_valid = 1'b1; tick();
    data = 8'h62; tick();
    in_valid = 1'b0; tick(); tick();
    #1;
    n_checks++; if (count !== 3'd2 || out_valid !== 1'b1 || q !== 8'h61) begin n_fail++; $display("FAIL refill got=%0d/%b/%h exp=2/1/61", count, out_valid, q); end
    en = 1'b0; flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_en0_in_ready got=%b exp=0", in_ready); end
    tick();
    en = 1'b1; flush = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_en0_cleared got=%0d/%b exp=0/0", count, out_valid); end
    data = 8'h71; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick(); tick(); tick();
    #1;
    n_checks++; if (count !== 3'd1 || out_valid !== 1'b1 || q !== 8'h71) begin n_fail++; $display("FAIL prereset got=%0d/%b/%h exp=1/1/71", count, out_valid, q); end
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (q !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_out got=%h/%b exp=00/0", q, out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_reset_count got=%0d exp=0", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_in_ready got=%b exp=0", in_ready); end
    reset = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_release_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_enable();
    test_flush_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
